// File: rtl/zx_vram_arbiter.sv
// Video RAM arbiter: shares one RAM port between ULA bitmap/attribute fetches
// and CPU accesses using a 16-phase line-locked slot schedule of 4-clock subslots.
module zx_vram_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk14,
  input  logic              rst,
  input  logic              line_start,
  input  logic              screen_active,
  input  logic [ADDR_W-1:0] bmp_addr,
  input  logic [ADDR_W-1:0] attr_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [7:0]        bmp_data,
  output logic [7:0]        attr_data,
  output logic              bmp_valid,
  output logic              attr_valid,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait
);

  typedef enum logic [1:0] {IDLE, BMP, ATTR, CPU} state_t;

  state_t     state;
  logic [3:0] ph;
  logic       cpu_we_q;
  logic [1:0] c;
  logic [1:0] k;

  assign c = ph[1:0];
  assign k = ph[3:2];

  assign cpu_wait = cpu_req & ~cpu_ack;

  always_ff @(posedge clk14) begin
    if (rst) begin
      ph         <= '0;
      state      <= IDLE;
      cpu_we_q   <= 1'b0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_rd     <= 1'b0;
      ram_wr     <= 1'b0;
      bmp_data   <= '0;
      attr_data  <= '0;
      cpu_rdata  <= '0;
      bmp_valid  <= 1'b0;
      attr_valid <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      bmp_valid  <= 1'b0;
      attr_valid <= 1'b0;
      cpu_ack    <= 1'b0;
      ph         <= line_start ? 4'd0 : ph + 4'd1;

      // line_start realigns the schedule: any access in flight is dropped
      // without a strobe, and a still-held cpu_req is picked up at the next c=0.
      if (line_start) begin
        state  <= IDLE;
        ram_rd <= 1'b0;
        ram_wr <= 1'b0;
      end else begin
        case (c)
          2'd0: begin
            state  <= IDLE;
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            if (screen_active && k == 2'd0) begin
              state  <= BMP;
              ram_a  <= bmp_addr;
              ram_rd <= 1'b1;
            end else if (screen_active && k == 2'd1) begin
              state  <= ATTR;
              ram_a  <= attr_addr;
              ram_rd <= 1'b1;
            end else if (cpu_req) begin
              state    <= CPU;
              ram_a    <= cpu_addr;
              ram_dout <= cpu_wdata;
              cpu_we_q <= cpu_we;
              ram_rd   <= ~cpu_we;
              ram_wr   <= cpu_we;
            end
          end
          2'd2: begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            case (state)
              BMP: begin
                bmp_data  <= ram_din;
                bmp_valid <= 1'b1;
              end
              ATTR: begin
                attr_data  <= ram_din;
                attr_valid <= 1'b1;
              end
              CPU: begin
                if (!cpu_we_q) cpu_rdata <= ram_din;
                cpu_ack <= 1'b1;
              end
              default: ;
            endcase
          end
          2'd3: state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Randomized and directed checks of zx_vram_arbiter against a slot-schedule
// reference model that tracks each access by its age since launch.
module tb_zx_vram_arbiter;

  localparam int AW = 14;

  logic          clk14 = 1'b0;
  logic          rst = 1'b1;
  logic          line_start = 1'b0;
  logic          screen_active = 1'b0;
  logic [AW-1:0] bmp_addr = '0;
  logic [AW-1:0] attr_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    ram_din;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout;
  logic          ram_rd, ram_wr;
  logic [7:0]    bmp_data, attr_data, cpu_rdata;
  logic          bmp_valid, attr_valid, cpu_ack, cpu_wait;

  always #5 clk14 = ~clk14;

  assign ram_din = ram_a[7:0] ^ 8'h5A;

  zx_vram_arbiter #(.ADDR_W(AW)) dut (
    .clk14(clk14), .rst(rst), .line_start(line_start), .screen_active(screen_active),
    .bmp_addr(bmp_addr), .attr_addr(attr_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .ram_din(ram_din), .ram_a(ram_a),
    .ram_dout(ram_dout), .ram_rd(ram_rd), .ram_wr(ram_wr), .bmp_data(bmp_data),
    .attr_data(attr_data), .bmp_valid(bmp_valid), .attr_valid(attr_valid),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: kind 0=none 1=bmp 2=attr 3=cpu; age = edges since launch
  int            m_ph = 0;
  int            m_kind = 0;
  int            m_age = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] e_a = '0;
  logic [7:0]    e_dout = '0, e_bmp = '0, e_attr = '0, e_rdata = '0;
  logic          e_bv = 1'b0, e_av = 1'b0, e_ack = 1'b0, e_rd = 1'b0, e_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t ph=%0d)", tag, got, exp, $time, m_ph);
    end
  endtask

  task automatic model_edge();
    logic [7:0] d;
    if (rst) begin
      m_ph = 0; m_kind = 0; m_age = 0;
      e_a = '0; e_dout = '0; e_bmp = '0; e_attr = '0; e_rdata = '0;
      e_bv = 0; e_av = 0; e_ack = 0; e_rd = 0; e_wr = 0;
      return;
    end
    e_bv = 0; e_av = 0; e_ack = 0;
    if (line_start) begin
      m_kind = 0;
      m_ph = 0;
    end else begin
      if (m_kind != 0) begin
        m_age++;
        if (m_age == 3) begin
          d = e_a[7:0] ^ 8'h5A;
          case (m_kind)
            1: begin e_bmp = d; e_bv = 1; end
            2: begin e_attr = d; e_av = 1; end
            default: begin if (!m_we) e_rdata = d; e_ack = 1; end
          endcase
        end else if (m_age == 4) m_kind = 0;
      end
      if (m_ph % 4 == 0) begin
        if (screen_active && m_ph / 4 == 0) begin m_kind = 1; e_a = bmp_addr; end
        else if (screen_active && m_ph / 4 == 1) begin m_kind = 2; e_a = attr_addr; end
        else if (cpu_req) begin
          m_kind = 3; e_a = cpu_addr; e_dout = cpu_wdata; m_we = cpu_we;
        end
        if (m_kind != 0) m_age = 1;
      end
      m_ph = (m_ph + 1) % 16;
    end
    e_rd = (m_kind != 0) && (m_age < 3) && !(m_kind == 3 && m_we);
    e_wr = (m_kind == 3) && m_we && (m_age < 3);
  endtask

  task automatic step();
    @(posedge clk14);
    model_edge();
    #1;
    check("ram_a", 32'(ram_a), 32'(e_a));
    check("ram_dout", 32'(ram_dout), 32'(e_dout));
    check("ram_rd", 32'(ram_rd), 32'(e_rd));
    check("ram_wr", 32'(ram_wr), 32'(e_wr));
    check("rd_wr_excl", 32'(ram_rd & ram_wr), 32'd0);
    check("bmp_data", 32'(bmp_data), 32'(e_bmp));
    check("attr_data", 32'(attr_data), 32'(e_attr));
    check("bmp_valid", 32'(bmp_valid), 32'(e_bv));
    check("attr_valid", 32'(attr_valid), 32'(e_av));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    check("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    check("cpu_wait", 32'(cpu_wait), 32'(cpu_req & ~e_ack));
  endtask

  task automatic wait_ph(input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_ph != p && n < 40);
    check("wait_ph_timeout", 32'(m_ph), 32'(p));
  endtask

  initial begin
    int acks;
    int n;
    // reset state
    step(); step();
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_rd", 32'(ram_rd), 32'd0);
    check("rst_bmp_data", 32'(bmp_data), 32'd0);
    check("rst_ack", 32'(cpu_ack), 32'd0);

    // Test 1: ULA fetches
    screen_active = 1'b1; bmp_addr = 14'h0000; attr_addr = 14'h1800;
    rst = 1'b0;
    for (int p = 1; p < 16; p++) begin
      step();
      check("t1_rd", 32'(ram_rd), 32'(p == 1 || p == 2 || p == 5 || p == 6));
      if (p == 3) begin
        check("t1_bmp_valid", 32'(bmp_valid), 32'd1);
        check("t1_bmp_data", 32'(bmp_data), 32'h5A);
      end
      if (p == 7) begin
        check("t1_attr_valid", 32'(attr_valid), 32'd1);
        check("t1_attr_data", 32'(attr_data), 32'h5A);
      end
    end

    // Test 2: CPU read delayed behind ULA subslots
    wait_ph(0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    for (int p = 1; p < 12; p++) begin
      step();
      check("t2_ack", 32'(cpu_ack), 32'(p == 11));
      if (p <= 10) check("t2_wait", 32'(cpu_wait), 32'd1);
      if (p == 9) check("t2_ram_a", 32'(ram_a), 32'h0123);
    end
    check("t2_rdata", 32'(cpu_rdata), 32'h79);
    cpu_req = 1'b0;

    // Test 3: CPU write with screen off
    screen_active = 1'b0;
    wait_ph(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2000; cpu_wdata = 8'hA5;
    for (int p = 2; p < 8; p++) begin
      step();
      check("t3_wr", 32'(ram_wr), 32'(p == 5 || p == 6));
      check("t3_rd", 32'(ram_rd), 32'd0);
      check("t3_ack", 32'(cpu_ack), 32'(p == 7));
      if (p == 5 || p == 6) begin
        check("t3_ram_a", 32'(ram_a), 32'h2000);
        check("t3_dout", 32'(ram_dout), 32'hA5);
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;

    // Test 4: line_start aborts a CPU read in c=1, then it is retried
    wait_ph(0);
    cpu_req = 1'b1; cpu_addr = 14'h0042;
    step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check("t4_rd_abort", 32'(ram_rd), 32'd0);
    check("t4_no_ack", 32'(cpu_ack), 32'd0);
    check("t4_wait", 32'(cpu_wait), 32'd1);
    n = 0;
    while (!cpu_ack && n < 20) begin step(); n++; end
    check("t4_retry_ack", 32'(cpu_ack), 32'd1);
    check("t4_rdata", 32'(cpu_rdata), 32'h42 ^ 32'h5A);
    cpu_req = 1'b0;

    // Test 5: reset during BMP c=2
    screen_active = 1'b1; bmp_addr = 14'h0333;
    wait_ph(2);
    rst = 1'b1;
    step();
    check("t5_no_valid", 32'(bmp_valid), 32'd0);
    check("t5_bmp_data", 32'(bmp_data), 32'd0);
    check("t5_ram_a", 32'(ram_a), 32'd0);
    check("t5_rd", 32'(ram_rd), 32'd0);
    rst = 1'b0;
    step();
    check("t5_first_rd", 32'(ram_rd), 32'd1);
    check("t5_first_a", 32'(ram_a), 32'h0333);
    step(); step();
    check("t5_first_valid", 32'(bmp_valid), 32'd1);

    // Test 6: back-to-back CPU accesses with screen off
    screen_active = 1'b0;
    wait_ph(0);
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
    acks = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (cpu_ack) begin
        acks++;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
      end
    end
    check("t6_ack_count", 32'(acks), 32'd16);
    cpu_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      rst = ($urandom_range(0, 255) == 0);
      line_start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) screen_active = ~screen_active;
      bmp_addr = AW'($urandom);
      attr_addr = AW'($urandom);
      if (cpu_req && e_ack && $urandom_range(0, 1) == 0) cpu_req = 1'b0;
      else if (cpu_req && e_ack) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
